// File: rtl/instruction_fetch_unit.sv
// Fetches 16-bit instructions over a req/ack port, latches IR, decodes opcode IR[3:0] and owns the PC.
// Latency: mem_ack in cycle N -> valid in N+1; at least 2 cycles per instruction.
// Backpressure: stall holds ISSUE with stable outputs and PC; HALTED is left only through reset.
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_data,
    input  logic        stall,
    input  logic        jmp_taken,
    input  logic [15:0] jmp_target,
    output logic [15:0] pc,
    output logic [3:0]  i4_7,
    output logic [3:0]  i8_11,
    output logic [3:0]  i12_15,
    output logic        ri,
    output logic        st,
    output logic        jmp,
    output logic        fn,
    output logic        valid,
    output logic        illegal,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_ISSUE  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [3:0] OP_ST   = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hE;
    localparam logic [3:0] OP_ILL  = 4'hF;

    state_t      state, state_nxt;
    logic [15:0] ir;
    logic [15:0] pc_nxt;
    logic [3:0]  op;
    logic        dec_ri, dec_st, dec_jmp, dec_fn, dec_ill;

    assign op = ir[3:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            ir    <= 16'h0000;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (state == S_FETCH && mem_ack) begin
                ir <= mem_data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            S_IDLE: state_nxt = S_FETCH;
            S_FETCH: begin
                if (mem_ack) begin
                    pc_nxt    = pc + 16'd1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A pending redirect waits with the stall and lands on the consume cycle.
                if (!stall) begin
                    state_nxt = (op == OP_HALT) ? S_HALTED : S_FETCH;
                    if (op == OP_JMP && jmp_taken) begin
                        pc_nxt = jmp_target;
                    end
                end
            end
            default: state_nxt = S_HALTED;
        endcase
    end

    always_comb begin
        dec_ri  = 1'b0;
        dec_st  = 1'b0;
        dec_jmp = 1'b0;
        dec_fn  = 1'b0;
        dec_ill = 1'b0;
        case (op)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
            4'h6, 4'h7, 4'h8, 4'h9: dec_fn = 1'b1;
            4'hA, 4'hB: begin
                dec_fn = 1'b1;
                dec_ri = 1'b1;
            end
            OP_ST:  dec_st  = 1'b1;
            OP_JMP: dec_jmp = 1'b1;
            OP_ILL: dec_ill = 1'b1;
            default: ;
        endcase
    end

    assign valid    = (state == S_ISSUE);
    assign halted   = (state == S_HALTED);
    assign mem_req  = (state == S_FETCH);
    assign mem_addr = pc;

    // Downstream writes on fn every cycle, so all controls are forced low outside ISSUE.
    assign ri      = valid & dec_ri;
    assign st      = valid & dec_st;
    assign jmp     = valid & dec_jmp;
    assign fn      = valid & dec_fn;
    assign illegal = valid & dec_ill;

    assign i4_7   = ir[7:4];
    assign i8_11  = ir[11:8];
    assign i12_15 = ir[15:12];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized instruction stream vs. a PC/decode model.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic        stall;
    logic        jmp_taken;
    logic [15:0] jmp_target;
    logic [15:0] pc;
    logic [3:0]  i4_7, i8_11, i12_15;
    logic        ri, st, jmp, fn, valid, illegal, halted;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] ref_pc;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .stall(stall), .jmp_taken(jmp_taken), .jmp_target(jmp_target),
        .pc(pc), .i4_7(i4_7), .i8_11(i8_11), .i12_15(i12_15),
        .ri(ri), .st(st), .jmp(jmp), .fn(fn),
        .valid(valid), .illegal(illegal), .halted(halted)
    );

    // Expected {ri,st,jmp,fn,illegal} straight from the opcode table.
    function automatic logic [4:0] exp_ctrl(input logic [3:0] op);
        if (op >= 4'h1 && op <= 4'h9) return 5'b00010;
        if (op == 4'hA || op == 4'hB) return 5'b10010;
        if (op == 4'hC) return 5'b01000;
        if (op == 4'hD) return 5'b00100;
        if (op == 4'hF) return 5'b00001;
        return 5'b00000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_word(input logic [15:0] d, input int waits);
        repeat (waits) tick();
        mem_ack  = 1'b1;
        mem_data = d;
        tick();
        mem_ack  = 1'b0;
        mem_data = 16'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_ack = 1'b0; mem_data = 16'h0; stall = 1'b0;
        jmp_taken = 1'b0; jmp_target = 16'h0;
        repeat (3) tick();
        n_checks++;
        if ({mem_req, valid, halted, fn, illegal} !== 5'b0 || pc !== 16'h0000 || mem_addr !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_state: req/valid/halted/fn/ill=%b pc=%h addr=%h, want 00000 0000 0000",
                     {mem_req, valid, halted, fn, illegal}, pc, mem_addr);
        end
        rst = 1'b1;
        n_checks++;
        if (mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: mem_req=%b want 0", mem_req);
        end
        tick();
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_to_fetch: mem_req=%b addr=%h want 1 0000", mem_req, mem_addr);
        end
        ref_pc = 16'h0000;
    endtask

    task automatic test_fetch();
        fetch_word(16'h2121, 0);
        ref_pc = ref_pc + 16'd1;
        n_checks++;
        if (valid !== 1'b1 || fn !== 1'b1 || ri !== 1'b0 || mem_req !== 1'b0 ||
            i4_7 !== 4'h2 || i8_11 !== 4'h1 || i12_15 !== 4'h2 || pc !== 16'h0001) begin
            n_fail++;
            $display("FAIL fetch_issue: v=%b fn=%b ri=%b req=%b f=%h%h%h pc=%h want 1 1 0 0 212 0001",
                     valid, fn, ri, mem_req, i12_15, i8_11, i4_7, pc);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (valid !== 1'b1 || fn !== 1'b1 || mem_req !== 1'b0 || pc !== 16'h0001) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: v=%b fn=%b req=%b pc=%h want 1 1 0 0001", i, valid, fn, mem_req, pc);
            end
        end
        stall = 1'b0;
        tick();
        n_checks++;
        if (mem_req !== 1'b1 || valid !== 1'b0 || fn !== 1'b0 || mem_addr !== 16'h0001) begin
            n_fail++;
            $display("FAIL stall_release: req=%b v=%b fn=%b addr=%h want 1 0 0 0001", mem_req, valid, fn, mem_addr);
        end
    endtask

    task automatic test_reset_mid_fetch();
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || valid !== 1'b0 || pc !== 16'h0000 || {i12_15, i8_11, i4_7} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_mid_fetch: req=%b v=%b pc=%h ir=%h want 0 0 0000 000",
                     mem_req, valid, pc, {i12_15, i8_11, i4_7});
        end
        tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mid_refetch: req=%b addr=%h want 1 0000", mem_req, mem_addr);
        end
        ref_pc = 16'h0000;
    endtask

    task automatic test_jump();
        fetch_word(16'h000D, 1);
        n_checks++;
        if (jmp !== 1'b1 || fn !== 1'b0 || valid !== 1'b1 || pc !== 16'h0001) begin
            n_fail++;
            $display("FAIL jump_issue: jmp=%b fn=%b v=%b pc=%h want 1 0 1 0001", jmp, fn, valid, pc);
        end
        // Redirect presented while stalled must wait for the stall to drop.
        stall = 1'b1; jmp_taken = 1'b1; jmp_target = 16'h0040;
        repeat (2) tick();
        n_checks++;
        if (pc !== 16'h0001 || jmp !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL jump_stall_wins: pc=%h jmp=%b req=%b want 0001 1 0", pc, jmp, mem_req);
        end
        stall = 1'b0;
        tick();
        jmp_taken = 1'b0;
        n_checks++;
        if (jmp !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0040) begin
            n_fail++;
            $display("FAIL jump_redirect: jmp=%b req=%b addr=%h want 0 1 0040", jmp, mem_req, mem_addr);
        end
        ref_pc = 16'h0040;
    endtask

    task automatic test_wrap_illegal();
        fetch_word(16'h000D, 0);
        jmp_taken = 1'b1; jmp_target = 16'hFFFF;
        tick();
        jmp_taken = 1'b0;
        n_checks++;
        if (mem_addr !== 16'hFFFF || mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_setup: addr=%h req=%b want ffff 1", mem_addr, mem_req);
        end
        fetch_word(16'h000F, 2);
        n_checks++;
        if (illegal !== 1'b1 || valid !== 1'b1 || {ri, st, jmp, fn} !== 4'b0 || pc !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_illegal: ill=%b v=%b ctrl=%b pc=%h want 1 1 0000 0000",
                     illegal, valid, {ri, st, jmp, fn}, pc);
        end
        jmp_taken = 1'b1; jmp_target = 16'h1234;
        tick();
        jmp_taken = 1'b0;
        n_checks++;
        if (illegal !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
            n_fail++;
            $display("FAIL illegal_refetch: ill=%b req=%b addr=%h want 0 1 0000", illegal, mem_req, mem_addr);
        end
        ref_pc = 16'h0000;
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [15:0] word;
            logic [3:0]  op;
            int          waits, stalls;
            logic        jt;
            logic [15:0] tgt;
            op = 4'($urandom_range(0, 13));
            if (op == 4'hE) op = 4'hF;
            if (n % 5 == 0) op = 4'hD;
            word   = {12'($urandom), op};
            waits  = $urandom_range(0, 2);
            stalls = $urandom_range(0, 2);
            jt     = 1'($urandom);
            tgt    = 16'($urandom);
            n_checks++;
            if (mem_req !== 1'b1 || mem_addr !== ref_pc) begin
                n_fail++;
                $display("FAIL rand_fetch[%0d]: req=%b addr=%h want 1 %h", n, mem_req, mem_addr, ref_pc);
            end
            fetch_word(word, waits);
            ref_pc = ref_pc + 16'd1;
            stall = 1'b1; jmp_taken = jt; jmp_target = tgt;
            repeat (stalls) tick();
            n_checks++;
            if (valid !== 1'b1 || {ri, st, jmp, fn, illegal} !== exp_ctrl(op) ||
                {i12_15, i8_11, i4_7} !== word[15:4] || pc !== ref_pc) begin
                n_fail++;
                $display("FAIL rand_issue[%0d]: v=%b ctrl=%b f=%h pc=%h want 1 %b %h %h", n, valid,
                         {ri, st, jmp, fn, illegal}, {i12_15, i8_11, i4_7}, pc, exp_ctrl(op), word[15:4], ref_pc);
            end
            stall = 1'b0;
            tick();
            jmp_taken = 1'b0;
            if (op == 4'hD && jt) ref_pc = tgt;
        end
    endtask

    task automatic test_halt();
        fetch_word(16'h500E, 1);
        ref_pc = ref_pc + 16'd1;
        n_checks++;
        if (valid !== 1'b1 || {ri, st, jmp, fn, illegal} !== 5'b0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_issue: v=%b ctrl=%b halted=%b want 1 00000 0", valid, {ri, st, jmp, fn, illegal}, halted);
        end
        tick();
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (halted !== 1'b1 || valid !== 1'b0 || mem_req !== 1'b0 || pc !== ref_pc) begin
                n_fail++;
                $display("FAIL halt_hold[%0d]: halted=%b v=%b req=%b pc=%h want 1 0 0 %h",
                         i, halted, valid, mem_req, pc, ref_pc);
            end
            mem_ack  = ~mem_ack;
            mem_data = 16'h0001;
            tick();
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_reset_mid_fetch();
        test_jump();
        test_wrap_illegal();
        test_random();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
